// File: rtl/rv_pkg.sv
// rv_pkg: shared fetch FSM state type and pipeline constants for the RV32I core.
package rv_pkg;
  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: pipeline register with flush > stall > load > bubble priority.
module if_id_reg #(
  parameter int         W   = 32,
  parameter logic [W-1:0] NOP = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_stall,
  input  logic         i_load,
  input  logic [W-1:0] i_instr,
  input  logic [W-1:0] i_pc,
  input  logic [W-1:0] i_pcplus4,
  output logic [W-1:0] o_instr,
  output logic [W-1:0] o_pc,
  output logic [W-1:0] o_pcplus4,
  output logic         o_valid
);
  logic [W-1:0] r_instr, r_pc, r_pcplus4;
  logic         r_valid;
  logic         w_take;
  assign w_take = i_load && !i_flush;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_instr   <= NOP;
      r_pc      <= '0;
      r_pcplus4 <= '0;
      r_valid   <= 1'b0;
    end else if (i_flush || !i_stall) begin
      r_instr   <= w_take ? i_instr : NOP;
      r_pc      <= w_take ? i_pc : '0;
      r_pcplus4 <= w_take ? i_pcplus4 : '0;
      r_valid   <= w_take;
    end
  assign o_instr   = r_instr;
  assign o_pc      = r_pc;
  assign o_pcplus4 = r_pcplus4;
  assign o_valid   = r_valid;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns PCF, runs the single-outstanding imem handshake and feeds IF/ID.
module fetch_stage import rv_pkg::*; #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = rv_pkg::RESET_PC,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = rv_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  FetchBusyF,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD
);
  fetch_state_t          r_state, w_next;
  logic [DATA_WIDTH-1:0] r_pc, r_buf, w_instr, w_pcplus4;
  logic                  w_avail, w_adv, w_leave;
  assign w_avail    = (r_state == WAIT && imem_rvalid) || r_state == HOLD;
  assign w_instr    = r_state == HOLD ? r_buf : imem_rdata;
  assign w_adv      = w_avail && !StallF && !PCSrcE;
  assign w_leave    = w_adv || PCSrcE;
  assign w_pcplus4  = r_pc + DATA_WIDTH'(4);
  assign imem_req   = !rst && r_state == REQ;
  assign imem_addr  = r_pc;
  assign FetchBusyF = !w_avail;
  // A redirect with a request in flight must wait out the stale response in DROP.
  always_comb begin
    w_next = r_state;
    case (r_state)
      REQ:     w_next = imem_gnt ? (PCSrcE ? DROP : WAIT) : REQ;
      WAIT:    w_next = imem_rvalid ? (w_leave ? REQ : HOLD) : (PCSrcE ? DROP : WAIT);
      HOLD:    w_next = w_leave ? REQ : HOLD;
      default: w_next = imem_rvalid ? REQ : DROP;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= REQ;
      r_pc    <= RESET_PC;
      r_buf   <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= PCSrcE ? PCTargetE : w_adv ? w_pcplus4 : r_pc;
      if (r_state == WAIT && imem_rvalid && !w_leave) r_buf <= imem_rdata;
    end
  if_id_reg #(.W(DATA_WIDTH), .NOP(NOP_INSTR)) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (FlushD || PCSrcE),
    .i_stall   (StallD),
    .i_load    (w_adv),
    .i_instr   (w_instr),
    .i_pc      (r_pc),
    .i_pcplus4 (w_pcplus4),
    .o_instr   (InstrD),
    .o_pc      (PCD),
    .o_pcplus4 (PCPlus4D),
    .o_valid   (ValidD)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed table plus reset sequence against a variable-latency imem model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 0, rst = 1;
  logic        StallF = 0, StallD = 0, FlushD = 0, PCSrcE = 0;
  logic [31:0] PCTargetE = 0;
  logic        imem_req, imem_gnt, imem_rvalid, FetchBusyF, ValidD;
  logic [31:0] imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
  logic        gen = 1;
  int          lat = 1;
  int          checks = 0, errors = 0;
  logic        m_busy;
  int          m_cnt, grants8;
  logic [31:0] m_addr;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 0 ? 32'h0050_0093 : a + 32'h0100_0013;
  endfunction

  assign imem_gnt    = imem_req && gen;
  assign imem_rvalid = m_busy && m_cnt == 0;
  assign imem_rdata  = imem_rvalid ? mem_word(m_addr) : 32'hDEAD_BEEF;

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_busy <= 0;
      m_cnt  <= 0;
      m_addr <= 0;
    end else if (imem_req && imem_gnt) begin
      m_busy <= 1;
      m_cnt  <= lat - 1;
      m_addr <= imem_addr;
      if (imem_addr == 32'd8) grants8 <= grants8 + 1;
    end else if (m_busy) begin
      if (m_cnt == 0) m_busy <= 0;
      else m_cnt <= m_cnt - 1;
    end

  fetch_stage dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .FetchBusyF(FetchBusyF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic sf, sd, fd, pcs;
    logic [31:0] tgt;
    int lat;
    logic gen, req;
    logic [31:0] addr;
    logic busy;
    logic [31:0] instr, pcd, p4;
    logic v;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input logic sf, sd, fd, pcs, input logic [31:0] tgt, input int l,
                              input logic g, req, input logic [31:0] addr, input logic busy,
                              input logic [31:0] instr, pcd, p4, input logic v);
    vec_t r;
    r.sf = sf; r.sd = sd; r.fd = fd; r.pcs = pcs; r.tgt = tgt; r.lat = l; r.gen = g;
    r.req = req; r.addr = addr; r.busy = busy; r.instr = instr; r.pcd = pcd; r.p4 = p4; r.v = v;
    return r;
  endfunction

  initial begin
    grants8 = 0;
    tv.push_back(mk(0,0,0,0, 0, 1,1, 1, 32'h0,   1, NOP, 0, 0, 0));
    tv.push_back(mk(0,0,0,0, 0, 1,1, 0, 32'h0,   0, NOP, 0, 0, 0));
    tv.push_back(mk(0,0,0,0, 0, 1,1, 1, 32'h4,   1, mem_word(0), 0, 4, 1));
    tv.push_back(mk(0,0,0,0, 0, 1,1, 0, 32'h4,   0, NOP, 0, 0, 0));
    tv.push_back(mk(0,0,0,0, 0, 1,1, 1, 32'h8,   1, mem_word(4), 4, 8, 1));
    tv.push_back(mk(1,1,0,0, 0, 1,1, 0, 32'h8,   0, NOP, 0, 0, 0));
    tv.push_back(mk(1,1,0,0, 0, 1,1, 0, 32'h8,   0, NOP, 0, 0, 0));
    tv.push_back(mk(1,1,0,0, 0, 1,1, 0, 32'h8,   0, NOP, 0, 0, 0));
    tv.push_back(mk(0,0,0,0, 0, 1,1, 0, 32'h8,   0, NOP, 0, 0, 0));
    tv.push_back(mk(0,0,0,0, 0, 3,1, 1, 32'hC,   1, mem_word(8), 8, 12, 1));
    tv.push_back(mk(0,0,0,1, 32'h100, 3,1, 0, 32'hC, 1, NOP, 0, 0, 0));
    tv.push_back(mk(0,0,0,0, 0, 3,1, 0, 32'h100, 1, NOP, 0, 0, 0));
    tv.push_back(mk(0,0,0,0, 0, 3,1, 0, 32'h100, 1, NOP, 0, 0, 0));
    tv.push_back(mk(0,0,0,0, 0, 1,1, 1, 32'h100, 1, NOP, 0, 0, 0));
    tv.push_back(mk(0,0,0,1, 32'h200, 1,1, 0, 32'h100, 0, NOP, 0, 0, 0));
    tv.push_back(mk(0,0,0,0, 0, 1,1, 1, 32'h200, 1, NOP, 0, 0, 0));
    tv.push_back(mk(0,0,0,0, 0, 1,1, 0, 32'h200, 0, NOP, 0, 0, 0));
    tv.push_back(mk(0,0,0,1, 32'hFFFF_FFFC, 1,0, 1, 32'h204, 1, mem_word(32'h200), 32'h200, 32'h204, 1));
    tv.push_back(mk(0,0,0,0, 0, 1,1, 1, 32'hFFFF_FFFC, 1, NOP, 0, 0, 0));
    tv.push_back(mk(0,0,0,0, 0, 1,1, 0, 32'hFFFF_FFFC, 0, NOP, 0, 0, 0));
    tv.push_back(mk(0,0,0,0, 0, 1,1, 1, 32'h0, 1, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 0, 1));
    tv.push_back(mk(0,0,1,0, 0, 1,1, 0, 32'h0,   0, NOP, 0, 0, 0));
    tv.push_back(mk(0,0,0,0, 0, 3,1, 1, 32'h4,   1, NOP, 0, 0, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_valid", ValidD, 0);
    rst = 0;
    foreach (tv[i]) begin
      StallF = tv[i].sf; StallD = tv[i].sd; FlushD = tv[i].fd;
      PCSrcE = tv[i].pcs; PCTargetE = tv[i].tgt; lat = tv[i].lat; gen = tv[i].gen;
      #1;
      chk($sformatf("s%0d_req", i), imem_req, tv[i].req);
      chk($sformatf("s%0d_addr", i), imem_addr, tv[i].addr);
      chk($sformatf("s%0d_busy", i), FetchBusyF, tv[i].busy);
      chk($sformatf("s%0d_instr", i), InstrD, tv[i].instr);
      chk($sformatf("s%0d_valid", i), ValidD, tv[i].v);
      if (tv[i].v) begin
        chk($sformatf("s%0d_pcd", i), PCD, tv[i].pcd);
        chk($sformatf("s%0d_p4", i), PCPlus4D, tv[i].p4);
      end
      @(negedge clk);
    end
    chk("grants_at_8", grants8, 1);
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0;
    rst = 1;
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_addr", imem_addr, 0);
    chk("mid_rst_instr", InstrD, NOP);
    chk("mid_rst_valid", ValidD, 0);
    chk("mid_rst_pcd", PCD, 0);
    chk("mid_rst_p4", PCPlus4D, 0);
    @(negedge clk);
    rst = 0; lat = 1;
    #1;
    chk("post_rst_req", imem_req, 1);
    chk("post_rst_addr", imem_addr, 0);
    chk("post_rst_busy", FetchBusyF, 1);
    @(negedge clk);
    chk("post_rst_wait_busy", FetchBusyF, 0);
    chk("post_rst_wait_req", imem_req, 0);
    @(negedge clk);
    chk("post_rst_instr", InstrD, mem_word(0));
    chk("post_rst_pcd", PCD, 0);
    chk("post_rst_p4", PCPlus4D, 4);
    chk("post_rst_validd", ValidD, 1);
    chk("post_rst_next_addr", imem_addr, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
